// File: rtl/lsu_pkg.sv
// Shared definitions for the load/store unit: access-size codes, FSM states
// and small address helpers used at request acceptance.
package lsu_pkg;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_READ  = 2'd1,
    ST_WRITE = 2'd2,
    ST_RESP  = 2'd3
  } lsu_state_e;

  // Size code 2'b11 behaves exactly like a word access.
  function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] lo);
    case (size)
      SZ_BYTE: return 1'b0;
      SZ_HALF: return lo[0];
      default: return |lo;
    endcase
  endfunction

  function automatic logic [1:0] align_lo(input logic [1:0] size, input logic [1:0] lo);
    case (size)
      SZ_BYTE: return lo;
      SZ_HALF: return {lo[1], 1'b0};
      default: return 2'b00;
    endcase
  endfunction

endpackage

// File: rtl/lsu_lane_align.sv
// Combinational lane steering: extracts and extends load data, and merges
// right-aligned sub-word store data into the word read from memory.
module lsu_lane_align
  import lsu_pkg::*;
(
  input  logic [1:0]  i_size,
  input  logic        i_unsigned,
  input  logic [1:0]  i_addr_lo,
  input  logic [31:0] i_rdata,
  input  logic [31:0] i_wdata,
  output logic [31:0] o_load_data,
  output logic [31:0] o_merge_data
);

  logic [7:0]  w_byte;
  logic [15:0] w_half;

  always_comb begin
    case (i_addr_lo)
      2'd1:    w_byte = i_rdata[15:8];
      2'd2:    w_byte = i_rdata[23:16];
      2'd3:    w_byte = i_rdata[31:24];
      default: w_byte = i_rdata[7:0];
    endcase
    w_half = i_addr_lo[1] ? i_rdata[31:16] : i_rdata[15:0];

    o_load_data  = i_rdata;
    o_merge_data = i_wdata;
    case (i_size)
      SZ_BYTE: begin
        o_load_data  = {{24{w_byte[7] & ~i_unsigned}}, w_byte};
        o_merge_data = i_rdata;
        case (i_addr_lo)
          2'd1:    o_merge_data[15:8]  = i_wdata[7:0];
          2'd2:    o_merge_data[23:16] = i_wdata[7:0];
          2'd3:    o_merge_data[31:24] = i_wdata[7:0];
          default: o_merge_data[7:0]   = i_wdata[7:0];
        endcase
      end
      SZ_HALF: begin
        o_load_data  = {{16{w_half[15] & ~i_unsigned}}, w_half};
        o_merge_data = i_rdata;
        if (i_addr_lo[1]) o_merge_data[31:16] = i_wdata[15:0];
        else              o_merge_data[15:0]  = i_wdata[15:0];
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// Load/store unit between core and single-port word memory; sub-word stores
// use read-modify-write. Define LSU_MISALIGN_TRAP_EN to trap misaligned accesses.
module load_store_unit
  import lsu_pkg::*;
#(
  parameter int ADDR_W = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_write,
  input  logic [1:0]        req_size,
  input  logic              req_unsigned,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [31:0]       req_wdata,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [31:0]       rsp_rdata,
  output logic              rsp_error,
  output logic [ADDR_W-1:0] mem_address,
  output logic [31:0]       mem_wdata,
  input  logic [31:0]       mem_rdata,
  output logic              mem_we,
  output lsu_state_e        dbg_state
);

  // Handshake: a request transfers on a clock edge where req_valid && req_ready;
  // a response transfers on an edge where rsp_valid && rsp_ready, and rsp_*
  // stay stable while rsp_valid is high and rsp_ready is low.

  lsu_state_e        r_state;
  logic              r_req_ready;
  logic              r_rsp_valid;
  logic [31:0]       r_rsp_rdata;
  logic              r_mem_we;
  logic [ADDR_W-1:0] r_mem_address;
  logic [31:0]       r_mem_wdata;
  logic              r_write;
  logic [1:0]        r_size;
  logic              r_unsigned;
  logic [1:0]        r_lo;
  logic [31:0]       r_wdata;
  logic              w_misaligned;
  logic [31:0]       w_load_data;
  logic [31:0]       w_merge_data;

`ifdef LSU_MISALIGN_TRAP_EN
  logic r_rsp_error;
  assign w_misaligned = is_misaligned(req_size, req_addr[1:0]);
  assign rsp_error    = r_rsp_error;
`else
  assign w_misaligned = 1'b0;
  assign rsp_error    = 1'b0;
`endif

  lsu_lane_align u_lane_align (
    .i_size       (r_size),
    .i_unsigned   (r_unsigned),
    .i_addr_lo    (r_lo),
    .i_rdata      (mem_rdata),
    .i_wdata      (r_wdata),
    .o_load_data  (w_load_data),
    .o_merge_data (w_merge_data)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state       <= ST_IDLE;
      r_req_ready   <= 1'b1;
      r_rsp_valid   <= 1'b0;
      r_rsp_rdata   <= '0;
      r_mem_we      <= 1'b0;
      r_mem_address <= '0;
      r_mem_wdata   <= '0;
      r_write       <= 1'b0;
      r_size        <= SZ_BYTE;
      r_unsigned    <= 1'b0;
      r_lo          <= 2'b00;
      r_wdata       <= '0;
`ifdef LSU_MISALIGN_TRAP_EN
      r_rsp_error   <= 1'b0;
`endif
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (req_valid && r_req_ready) begin
            r_req_ready   <= 1'b0;
            r_write       <= req_write;
            r_size        <= req_size;
            r_unsigned    <= req_unsigned;
            r_lo          <= align_lo(req_size, req_addr[1:0]);
            r_wdata       <= req_wdata;
            r_mem_address <= {req_addr[ADDR_W-1:2], 2'b00};
            if (w_misaligned) begin
              r_rsp_valid <= 1'b1;
              r_rsp_rdata <= '0;
`ifdef LSU_MISALIGN_TRAP_EN
              r_rsp_error <= 1'b1;
`endif
              r_state     <= ST_RESP;
            end else if (req_write && req_size[1]) begin
              // Full-word stores need no read of the old word.
              r_mem_we    <= 1'b1;
              r_mem_wdata <= req_wdata;
              r_state     <= ST_WRITE;
            end else begin
              r_state <= ST_READ;
            end
          end
        end
        ST_READ: begin
          if (r_write) begin
            r_mem_wdata <= w_merge_data;
            r_mem_we    <= 1'b1;
            r_state     <= ST_WRITE;
          end else begin
            r_rsp_valid <= 1'b1;
            r_rsp_rdata <= w_load_data;
`ifdef LSU_MISALIGN_TRAP_EN
            r_rsp_error <= 1'b0;
`endif
            r_state     <= ST_RESP;
          end
        end
        ST_WRITE: begin
          r_mem_we    <= 1'b0;
          r_rsp_valid <= 1'b1;
          r_rsp_rdata <= '0;
`ifdef LSU_MISALIGN_TRAP_EN
          r_rsp_error <= 1'b0;
`endif
          r_state     <= ST_RESP;
        end
        ST_RESP: begin
          if (rsp_ready) begin
            r_rsp_valid <= 1'b0;
            r_req_ready <= 1'b1;
            r_state     <= ST_IDLE;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign req_ready   = r_req_ready;
  assign rsp_valid   = r_rsp_valid;
  assign rsp_rdata   = r_rsp_rdata;
  assign mem_we      = r_mem_we;
  assign mem_address = r_mem_address;
  assign mem_wdata   = r_mem_wdata;
  assign dbg_state   = r_state;

endmodule

// File: doc/load_store_unit.md
Name: load_store_unit

Overview:
- Initiator-side memory access unit between the processor core and the single-port word memory.
- The memory has combinational read, synchronous write, word index taken from address[13:2], little-endian.
- Accepts byte/halfword/word load and store requests from the core and drives the memory's address, write-data and write-enable.
- Byte and halfword stores are done as a read-modify-write; load results are sign- or zero-extended.

Parameters:
ADDR_W, 32, width of request and memory address buses.

Ports:
clk  in  1  system clock, all state updates on posedge.
reset  in  1  asynchronous, active-high reset.
req_valid  in  1  core presents a request.
req_ready  out  1  unit can accept a request (high only in IDLE).
req_write  in  1  1 = store, 0 = load.
req_size  in  2  00 byte, 01 halfword, 10 word; 11 is treated as word.
req_unsigned  in  1  loads only: 1 = zero-extend, 0 = sign-extend.
req_addr  in  ADDR_W  byte address.
req_wdata  in  32  store data, right-aligned (byte in [7:0], half in [15:0]).
rsp_valid  out  1  response available.
rsp_ready  in  1  core consumes the response.
rsp_rdata  out  32  extended load data; 0 for stores and errors.
rsp_error  out  1  misaligned access (see Optional Feature).
mem_address  out  ADDR_W  word-aligned address to memory: {addr[ADDR_W-1:2],2'b00}.
mem_wdata  out  32  data to the memory's write-data input.
mem_rdata  in  32  data from the memory's combinational read output.
mem_we  out  1  memory write enable.

Behaviour:
- Reset (async): state IDLE.
  - req_ready=1; rsp_valid=0; rsp_rdata=0; rsp_error=0.
  - mem_we=0; mem_address=0; mem_wdata=0.
  - mem_we must drop immediately on reset assertion, including mid-write.
- States: IDLE, READ, WRITE, RESP.
- IDLE: req_valid&&req_ready latches write, size, unsigned, addr and wdata, then:
  - misaligned (feature on) -> RESP with error=1;
  - load or sub-word store -> READ;
  - word store -> WRITE.
- READ: mem_address=latched word address; mem_rdata captured at the clock edge.
  - Load: extract and extend into rsp_rdata -> RESP.
  - Sub-word store: merge into a word buffer -> WRITE.
- Merge: replace byte lane addr[1:0] (byte) or half lane addr[1] (half) with the low bits of wdata; other lanes are kept from mem_rdata.
- WRITE: mem_we=1 for exactly one cycle; mem_wdata = merged word, or raw wdata for a word store -> RESP.
- RESP: rsp_valid=1, held with rsp_rdata/rsp_error stable until rsp_ready; on rsp_ready -> IDLE.
  - rsp_ready may already be high on entry; the response then completes in one cycle.
- Latency from the accept edge to rsp_valid:
  - load: 2 cycles;
  - word store: 2 cycles;
  - byte/half store: 3 cycles;
  - error: 1 cycle.
- No new request is accepted in the same cycle the response completes (req_ready rises the cycle after).
- Load extraction:
  - byte from lane addr[1:0], half from lane addr[1];
  - sign-extend from bit 7/15 unless unsigned; word passes through.
- mem_address holds the latched address in all non-IDLE states; mem_we=0 in every state except WRITE.

Optional Feature:
- Macro LSU_MISALIGN_TRAP_EN.
- Defined:
  - a halfword with addr[0]=1, or a word with addr[1:0]!=0, gets an error response: rsp_error=1, rsp_rdata=0;
  - no memory write is issued.
- Undefined:
  - low address bits below the access size are forced to 0 (aligned down) and the access proceeds normally;
  - rsp_error is tied 0.

Decomposition:
- Shared package lsu_pkg holds:
  - size constants SZ_BYTE=2'b00, SZ_HALF=2'b01, SZ_WORD=2'b10;
  - the state enum.
- One combinational sub-module, lsu_lane_align, performs load extract/extend and store merge; the FSM stays in load_store_unit.

Test Plan:
- Memory word at 0x800 = 0x8899AABB, load byte signed at addr 0x803 -> rsp_rdata=0xFFFFFF88, rsp_valid 2 cycles after accept, mem_we never high.
- Same word, load half unsigned at 0x802 -> rsp_rdata=0x00008899; load word at 0x800 -> 0x8899AABB.
- Store byte 0x55 at 0x801 over word 0x11223344 -> exactly one mem_we pulse, mem_wdata=0x11225544, rsp_valid 3 cycles after accept, rsp_rdata=0.
- Word store 0xDEADBEEF at 0x804 with rsp_ready held low 4 cycles -> rsp_valid stays high 4 cycles, req_ready stays low, memory reads back 0xDEADBEEF.
- Feature on: load word at 0x802 -> rsp_error=1 one cycle after accept, no mem_we. Feature off: same access returns the word at 0x800, rsp_error=0.
- Assert reset during the WRITE state of a half store -> mem_we drops in the same cycle, memory word unchanged, req_ready=1 after reset.
